// File: rtl/aes_block_feeder_if.sv
// Upstream block transfer into the AES feeder: one 128-bit key and one 128-bit plaintext per beat.
interface aes_block_feeder_if;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_key;
    logic [127:0] s_pt;

    modport master (output s_valid, output s_key, output s_pt, input s_ready);
    modport slave  (input s_valid, input s_key, input s_pt, output s_ready);
endinterface

// File: rtl/aes_block_feeder.sv
// Buffers (key, plaintext) blocks and sequences the byte-serial AES core: reset pulse,
// 16 MSB-first key/state byte pairs, then waits for 16 output strobes under a watchdog.
module aes_block_feeder #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    aes_block_feeder_if.slave up,
    output logic              core_rst,
    output logic              core_enable,
    output logic [7:0]        core_key_byte,
    output logic [7:0]        core_state_byte,
    input  logic              core_ready,
    output logic              busy,
    output logic              err,
    output logic [15:0]       blocks_done
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CRST = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    logic [255:0]   mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  countNxt;
    logic [1:0]     state;
    logic [1:0]     stateNxt;
    logic [127:0]   keySh;
    logic [127:0]   ptSh;
    logic [3:0]     k;
    logic [4:0]     rc;
    logic [WDW-1:0] wd;
    logic           push;
    logic           pop;
    logic           lastReady;
    logic           timeout;

    // Ready depends only on occupancy, so a pop in the same cycle never frees a full FIFO early.
    assign up.s_ready = !rst && (count != FULL_CNT);
    assign push       = up.s_valid && up.s_ready;
    assign lastReady  = (state == RUN) && core_ready && (rc == 5'd15);
    assign timeout    = (state == RUN) && !lastReady && (wd == WD_LAST);
    assign countNxt   = count + CW'(push) - CW'(pop);

    always_comb begin
        stateNxt = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    stateNxt = CRST;
                    pop      = 1'b1;
                end
            end
            CRST: stateNxt = LOAD;
            LOAD: begin
                if (k == 4'd15) stateNxt = RUN;
            end
            RUN: begin
                if (lastReady) begin
                    stateNxt = IDLE;
                end else if (timeout) begin
                    // An aborted block hands straight over to the next queued one.
                    if (count != '0) begin
                        stateNxt = CRST;
                        pop      = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Block storage and the byte shifters carry no reset; only control is reset.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= {up.s_key, up.s_pt};
        if (pop) begin
            {keySh, ptSh} <= mem[rdPtr];
        end else if (stateNxt == LOAD) begin
            keySh <= keySh << 8;
            ptSh  <= ptSh << 8;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wrPtr           <= '0;
            rdPtr           <= '0;
            count           <= '0;
            k               <= '0;
            rc              <= '0;
            wd              <= '0;
            core_rst        <= 1'b1;
            core_enable     <= 1'b0;
            core_key_byte   <= 8'h00;
            core_state_byte <= 8'h00;
            busy            <= 1'b0;
            err             <= 1'b0;
            blocks_done     <= 16'h0000;
        end else begin
            state <= stateNxt;
            count <= countNxt;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);

            busy            <= (stateNxt != IDLE) || (countNxt != '0);
            err             <= timeout;
            core_rst        <= (stateNxt == CRST) || timeout;
            core_enable     <= (stateNxt == LOAD) || (stateNxt == RUN);
            core_key_byte   <= (stateNxt == LOAD) ? keySh[127:120] : 8'h00;
            core_state_byte <= (stateNxt == LOAD) ? ptSh[127:120] : 8'h00;
            if (lastReady) blocks_done <= blocks_done + 16'd1;

            case (state)
                CRST: k <= 4'd0;
                LOAD: begin
                    k  <= k + 4'd1;
                    rc <= 5'd0;
                    wd <= '0;
                end
                RUN: begin
                    if (core_ready) rc <= rc + 5'd1;
                    wd <= wd + WDW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_feeder.sv
// Bench for aes_block_feeder: block table, back-pressure, watchdog, reset and random traffic,
// with the byte stream predicted straight from each pushed (key, plaintext) pair.
module tb_aes_block_feeder;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int           gapMode;
        logic [7:0]   firstKey;
        logic [7:0]   firstSt;
        logic [7:0]   lastKey;
        logic [7:0]   lastSt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coreRst, coreEnable, coreReady, busy, err;
    logic [7:0]  coreKeyByte, coreStateByte;
    logic [15:0] blocksDone;

    aes_block_feeder_if up();

    aes_block_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (up),
        .core_rst        (coreRst),
        .core_enable     (coreEnable),
        .core_key_byte   (coreKeyByte),
        .core_state_byte (coreStateByte),
        .core_ready      (coreReady),
        .busy            (busy),
        .err             (err),
        .blocks_done     (blocksDone)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    int expDone = 0;
    int fixedGaps[16] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 0};

    vec_t         tv[4];
    vec_t         cv;
    string        tag;
    int           w;
    logic         ra;
    logic [15:0]  da;
    logic [7:0]   fk, fs, lk, ls;
    int           bw[4];
    logic         bRst[4];
    logic [15:0]  bDone[4];
    logic [127:0] bk[4], bp[4];
    logic [127:0] rk[6], rp[6];
    int           n;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // The core must never see enable while it is being reset.
    always @(negedge clk) begin
        if (!rst && coreRst === 1'b1 && coreEnable === 1'b1) begin
            nVec++;
            nMis++;
            $display("FAIL rst_enable_overlap: core_rst=1 core_enable=1, expected never both (t=%0t)", $time);
        end
    end

    task automatic doReset();
        rst = 1'b1;
        up.s_valid = 1'b0;
        coreReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expDone = 0;
    endtask

    task automatic pushBlock(input logic [127:0] key, input logic [127:0] pt,
                             output int waited, output logic rstAt, output logic [15:0] doneAt);
        @(negedge clk);
        up.s_valid = 1'b1;
        up.s_key   = key;
        up.s_pt    = pt;
        waited = 0;
        while (!up.s_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        rstAt  = coreRst;
        doneAt = blocksDone;
        if (!up.s_ready) begin
            nVec++;
            nMis++;
            $display("FAIL push_timeout: s_ready=0 after %0d cycles, expected 1", waited);
        end else begin
            @(posedge clk);
        end
        #1 up.s_valid = 1'b0;
    endtask

    // gapMode: -1 core never answers, -2 fixed gap table, >=0 random gaps 0..gapMode.
    task automatic streamBlock(input string t, input logic [127:0] key, input logic [127:0] pt,
                               input int gapMode, input bit already,
                               output logic [7:0] firstK, output logic [7:0] firstS,
                               output logic [7:0] lastK, output logic [7:0] lastS);
        int m;
        int gap;
        firstK = '0; firstS = '0; lastK = '0; lastS = '0;
        if (!already) @(negedge clk);
        m = 0;
        while (!(coreRst && !coreEnable) && m < 400) begin
            @(negedge clk);
            m++;
        end
        chk({t, " crst_seen"}, 128'(coreRst && !coreEnable), 128'(1));
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk($sformatf("%s byte%0d", t, j),
                128'({coreRst, coreEnable, err, coreKeyByte, coreStateByte}),
                128'({1'b0, 1'b1, 1'b0, key[127-8*j -: 8], pt[127-8*j -: 8]}));
            if (j == 0)  begin firstK = coreKeyByte; firstS = coreStateByte; end
            if (j == 15) begin lastK  = coreKeyByte; lastS  = coreStateByte; end
        end
        @(negedge clk);
        chk({t, " run_entry"}, 128'({coreRst, coreEnable, coreKeyByte, coreStateByte}),
            128'({1'b0, 1'b1, 16'h0000}));
        if (gapMode == -1) begin
            m = 0;
            while (!err && m < TIMEOUT + 20) begin
                @(negedge clk);
                m++;
            end
            chk({t, " wd_latency"}, 128'(m), 128'(TIMEOUT));
            chk({t, " wd_done_kept"}, 128'(blocksDone), 128'(expDone[15:0]));
            chk({t, " wd_core_rst"}, 128'({coreRst, coreEnable}), 128'(2'b10));
        end else begin
            for (int r = 0; r < 16; r++) begin
                gap = (gapMode == -2) ? fixedGaps[r] : int'($urandom_range(gapMode, 0));
                coreReady = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    chk($sformatf("%s hold_gap%0d", t, r), 128'(coreEnable), 128'(1));
                end
                coreReady = 1'b1;
                @(negedge clk);
                if (r < 15) chk($sformatf("%s hold_rdy%0d", t, r), 128'(coreEnable), 128'(1));
            end
            coreReady = 1'b0;
            expDone++;
            chk({t, " exit"}, 128'({coreRst, coreEnable}), 128'(0));
            chk({t, " done_cnt"}, 128'(blocksDone), 128'(expDone[15:0]));
        end
    endtask

    initial begin
        #400000;
        nMis++;
        $display("FAIL global_timeout: still running at %0t, expected to finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $fatal(1, "bench timed out");
    end

    initial begin
        tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  0, 8'h00, 8'h00, 8'h0f, 8'hff};
        tv[1] = '{{128{1'b1}}, 128'h0, 2, 8'hff, 8'h00, 8'hff, 8'h00};
        tv[2] = '{128'h0123456789abcdeffedcba9876543210, 128'h80000000000000000000000000000001,
                  -2, 8'h01, 8'h80, 8'h10, 8'h01};
        tv[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  1, 8'h2b, 8'h32, 8'h3c, 8'h34};

        up.s_valid = 1'b0;
        up.s_key   = '0;
        up.s_pt    = '0;
        coreReady  = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            128'({coreRst, coreEnable, coreKeyByte, coreStateByte, busy, err, blocksDone}),
            128'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000}));
        chk("reset_s_ready", 128'(up.s_ready), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cv  = tv[i];
            tag = $sformatf("tv%0d", i);
            fork
                pushBlock(cv.key, cv.pt, w, ra, da);
                streamBlock(tag, cv.key, cv.pt, cv.gapMode, 1'b0, fk, fs, lk, ls);
            join
            chk({tag, " first_pair"}, 128'({fk, fs}), 128'({cv.firstKey, cv.firstSt}));
            chk({tag, " last_pair"}, 128'({lk, ls}), 128'({cv.lastKey, cv.lastSt}));
            chk({tag, " busy_after"}, 128'(busy), 128'(0));
        end

        // Core strobes while idle must not move anything.
        for (int i = 0; i < 12; i++) begin
            coreReady = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk($sformatf("idle_guard%0d", i), 128'({coreRst, coreEnable, busy, blocksDone}),
                128'({1'b0, 1'b0, 1'b0, expDone[15:0]}));
        end
        coreReady = 1'b0;

        for (int i = 0; i < 4; i++) begin
            bk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            bp[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        doReset();
        fork
            begin
                for (int i = 0; i < 4; i++) pushBlock(bk[i], bp[i], bw[i], bRst[i], bDone[i]);
            end
            begin
                for (int j = 0; j < 4; j++)
                    streamBlock($sformatf("bp%0d", j), bk[j], bp[j], 2, 1'b0, fk, fs, lk, ls);
            end
        join
        chk("bp first3_no_wait", 128'({bw[0] == 0, bw[1] == 0, bw[2] == 0}), 128'(3'b111));
        chk("bp push4_stalled", 128'(bw[3] > 0), 128'(1));
        chk("bp push4_at_pop", 128'({bRst[3], bDone[3]}), 128'({1'b1, 16'd1}));
        chk("bp total_done", 128'(blocksDone), 128'(16'd4));

        doReset();
        bk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        bp[0] = 128'h00112233445566778899aabbccddeeff;
        bk[1] = 128'hffeeddccbbaa99887766554433221100;
        bp[1] = 128'h0f0e0d0c0b0a09080706050403020100;
        fork
            begin
                pushBlock(bk[0], bp[0], w, ra, da);
                pushBlock(bk[1], bp[1], w, ra, da);
            end
            begin
                streamBlock("wd0", bk[0], bp[0], -1, 1'b0, fk, fs, lk, ls);
                streamBlock("wd1", bk[1], bp[1], -1, 1'b1, fk, fs, lk, ls);
                @(negedge clk);
                chk("wd idle_after", 128'({coreRst, coreEnable, err, busy}), 128'(0));
                chk("wd done_zero", 128'(blocksDone), 128'(0));
            end
        join

        doReset();
        bk[2] = 128'h1f1e1d1c1b1a19181716151413121110;
        bp[2] = 128'h2f2e2d2c2b2a29282726252423222120;
        fork
            begin
                pushBlock(bk[0], bp[0], w, ra, da);
                pushBlock(bk[1], bp[1], w, ra, da);
            end
            begin
                @(negedge clk);
                n = 0;
                while (!(coreRst && !coreEnable) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (8) @(negedge clk);
                chk("rst_mid at_byte7", 128'({coreEnable, coreKeyByte}), 128'({1'b1, bk[0][71:64]}));
                rst = 1'b1;
                @(negedge clk);
                chk("rst_mid outputs",
                    128'({coreRst, coreEnable, coreKeyByte, coreStateByte, busy, err, blocksDone, up.s_ready}),
                    128'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0}));
                rst = 1'b0;
                expDone = 0;
                repeat (4) @(negedge clk);
                chk("rst_mid fifo_empty", 128'({coreRst, coreEnable, busy}), 128'(0));
            end
        join
        fork
            pushBlock(bk[2], bp[2], w, ra, da);
            streamBlock("after_rst", bk[2], bp[2], 1, 1'b0, fk, fs, lk, ls);
        join

        for (int i = 0; i < 6; i++) begin
            rk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(20, 0)) @(negedge clk);
                    pushBlock(rk[i], rp[i], w, ra, da);
                end
            end
            begin
                for (int j = 0; j < 6; j++)
                    streamBlock($sformatf("rnd%0d", j), rk[j], rp[j], 2, 1'b0, fk, fs, lk, ls);
            end
        join
        @(negedge clk);
        chk("rnd final_idle", 128'({busy, blocksDone}), 128'({1'b0, expDone[15:0]}));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
